// File: rtl/bali_pkg.sv
// Shared definitions for the bytecode core: opcode constants,
// fetch FSM states and the instruction length decode function.
package bali_pkg;

  localparam logic [7:0] OP_BIPUSH       = 8'h10;
  localparam logic [7:0] OP_SIPUSH       = 8'h11;
  localparam logic [7:0] OP_LDC          = 8'h12;
  localparam logic [7:0] OP_ILOAD        = 8'h15;
  localparam logic [7:0] OP_ISTORE       = 8'h36;
  localparam logic [7:0] OP_IINC         = 8'h84;
  localparam logic [7:0] OP_IFEQ         = 8'h99;
  localparam logic [7:0] OP_GOTO         = 8'hA7;
  localparam logic [7:0] OP_TABLESWITCH  = 8'hAA;
  localparam logic [7:0] OP_LOOKUPSWITCH = 8'hAB;
  localparam logic [7:0] OP_INVOKESTATIC = 8'hB8;
  localparam logic [7:0] OP_WIDE         = 8'hC4;
  localparam logic [7:0] OP_IMPDEP2      = 8'hFF;

  typedef enum logic [1:0] {
    FS_ISSUE,
    FS_LATCH,
    FS_HOLD,
    FS_HALT
  } fetch_state_e;

  // Returns the instruction length in bytes; 0 marks an
  // opcode this core does not support.
  function automatic logic [1:0] op_length(
    input logic [7:0] op
  );
    logic ill;
    logic l2;
    logic l3;
    logic [1:0] len;
    ill = (op == OP_TABLESWITCH) ||
          (op == OP_LOOKUPSWITCH) ||
          (op == OP_WIDE) ||
          (op == OP_IMPDEP2);
    l2  = (op == OP_BIPUSH) ||
          (op == OP_LDC) ||
          (op == OP_ILOAD) ||
          (op == OP_ISTORE);
    l3  = (op == OP_SIPUSH) ||
          (op == OP_IINC) ||
          ((op >= OP_IFEQ) && (op <= OP_GOTO)) ||
          (op == OP_INVOKESTATIC);
    len = 2'd1;
    unique case (1'b1)
      ill:     len = 2'd0;
      l2:      len = 2'd2;
      l3:      len = 2'd3;
      default: len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational opcode length decoder.
// opcode in; len out (1..3, 0 when illegal); illegal out.
module instr_len_decode
  import bali_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len,
  output logic       illegal
);

  always_comb begin
    len     = op_length(opcode);
    illegal = (len == 2'd0);
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives program memory address, captures the
// returned bytes and presents one instruction per valid/ready
// handshake. Ports: clk, rst_n, programcounter, mem_opcode,
// mem_arg1, mem_arg2, instr_* (valid/ready/opcode/args/pc/len),
// redirect_valid, redirect_pc, illegal_op.
module instr_fetch
  import bali_pkg::*;
#(
  parameter int SIZE     = 65536,
  parameter int RESET_PC = 0,
  localparam int PC_LEN  = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_LEN-1:0] programcounter,
  input  logic [7:0]        mem_opcode,
  input  logic [7:0]        mem_arg1,
  input  logic [7:0]        mem_arg2,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [7:0]        instr_arg1,
  output logic [7:0]        instr_arg2,
  output logic [PC_LEN-1:0] instr_pc,
  output logic [1:0]        instr_len,
  input  logic              redirect_valid,
  input  logic [PC_LEN-1:0] redirect_pc,
  output logic              illegal_op
);

  localparam logic [PC_LEN-1:0] RST_PC =
    PC_LEN'(RESET_PC);
  localparam logic [PC_LEN:0] SIZE_W =
    (PC_LEN+1)'(SIZE);

  fetch_state_e      state_q, state_d;
  logic [PC_LEN-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [7:0]        opc_q, opc_d;
  logic [7:0]        arg1_q, arg1_d;
  logic [7:0]        arg2_q, arg2_d;
  logic [PC_LEN-1:0] ipc_q, ipc_d;
  logic [1:0]        len_q, len_d;
  logic              ill_q, ill_d;

  logic [1:0]        dec_len;
  logic              dec_ill;
  logic [PC_LEN:0]   pc_sum;
  logic [PC_LEN-1:0] pc_next;

  instr_len_decode u_len (
    .opcode  (mem_opcode),
    .len     (dec_len),
    .illegal (dec_ill)
  );

  // One extra bit so non-power-of-two SIZE still wraps
  always_comb begin
    pc_sum = {1'b0, pc_q} + (PC_LEN+1)'(len_q);
    if (pc_sum >= SIZE_W) begin
      pc_sum = pc_sum - SIZE_W;
    end
    pc_next = pc_sum[PC_LEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    opc_d   = opc_q;
    arg1_d  = arg1_q;
    arg2_d  = arg2_q;
    ipc_d   = ipc_q;
    len_d   = len_q;
    ill_d   = ill_q;
    // Redirect wins everything, including a
    // same-cycle handshake and in-flight data.
    if (redirect_valid) begin
      state_d = FS_ISSUE;
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else begin
      unique case (state_q)
        FS_ISSUE: begin
          state_d = FS_LATCH;
        end
        FS_LATCH: begin
          opc_d  = mem_opcode;
          arg1_d = (dec_len >= 2'd2) ? mem_arg1 : 8'h00;
          arg2_d = (dec_len == 2'd3) ? mem_arg2 : 8'h00;
          ipc_d  = pc_q;
          len_d  = dec_len;
          if (dec_ill) begin
            state_d = FS_HALT;
            valid_d = 1'b0;
            ill_d   = 1'b1;
          end else begin
            state_d = FS_HOLD;
            valid_d = 1'b1;
          end
        end
        FS_HOLD: begin
          if (instr_ready) begin
            pc_d    = pc_next;
            valid_d = 1'b0;
            state_d = FS_ISSUE;
          end
        end
        FS_HALT: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = FS_ISSUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_ISSUE;
      pc_q    <= RST_PC;
      valid_q <= 1'b0;
      opc_q   <= 8'h00;
      arg1_q  <= 8'h00;
      arg2_q  <= 8'h00;
      ipc_q   <= '0;
      len_q   <= 2'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      opc_q   <= opc_d;
      arg1_q  <= arg1_d;
      arg2_q  <= arg2_d;
      ipc_q   <= ipc_d;
      len_q   <= len_d;
      ill_q   <= ill_d;
    end
  end

  assign programcounter = pc_q;
  assign instr_valid    = valid_q;
  assign instr_opcode   = opc_q;
  assign instr_arg1     = arg1_q;
  assign instr_arg2     = arg2_q;
  assign instr_pc       = ipc_q;
  assign instr_len      = len_q;
  assign illegal_op     = ill_q;

endmodule
